dft_frame_scheduler: RTL and testbench



---
 rtl/dft_frame_scheduler_pkg.sv | 19 +
 rtl/dft_result_serializer.sv | 59 +++++
 rtl/dft_frame_scheduler.sv | 153 +++++++++++++++
 tb/tb_dft_frame_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_frame_scheduler_pkg.sv
// Shared types and default widths for the DFT frame scheduler and its result serializer.
package dft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_RUN      = 3'd2,
      ST_WAIT_ACC = 3'd3,
      ST_READOUT  = 3'd4
   } dft_state_e;

   localparam int DFT_IQ_WIDTH           = 16;
   localparam int DFT_WINDOW_WIDTH       = 18;
   localparam int DFT_ACCUM_WIDTH        = 48;
   localparam int DFT_NUM_BINS           = 16;
   localparam int DFT_SAMPLE_COUNT_WIDTH = 16;
   localparam int DFT_TIMEOUT_CYCLES     = 64;

endpackage

// File: rtl/dft_result_serializer.sv
// Walks the NUM_BINS accumulator results out one bin per res_* handshake once started,
// pulsing done after the final bin is taken.
module dft_result_serializer
   import dft_pkg::*;
#(
   parameter int  ACCUM_WIDTH = DFT_ACCUM_WIDTH,
   parameter int  NUM_BINS    = DFT_NUM_BINS,
   localparam int BIN_W       = $clog2(NUM_BINS)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  start_i,
   input  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0]  real_i,
   input  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0]  imag_i,
   output logic                                  res_valid_o,
   input  logic                                  res_ready_i,
   output logic [ACCUM_WIDTH-1:0]                res_real_o,
   output logic [ACCUM_WIDTH-1:0]                res_imag_o,
   output logic [BIN_W-1:0]                      res_bin_o,
   output logic                                  res_last_o,
   output logic                                  done_o
);

   logic             valid;
   logic [BIN_W-1:0] bin;
   logic             bin_last;

   assign bin_last = (bin == BIN_W'(NUM_BINS - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid  <= 1'b0;
         bin    <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (start_i) begin
            valid <= 1'b1;
            bin   <= '0;
         end else if (valid && res_ready_i) begin
            if (bin_last) begin
               valid  <= 1'b0;
               bin    <= '0;
               done_o <= 1'b1;
            end else begin
               bin <= bin + 1'b1;
            end
         end
      end
   end

   // Outputs are forced to zero whenever no bin is being offered.
   assign res_valid_o = valid;
   assign res_bin_o   = valid ? bin : '0;
   assign res_last_o  = valid && bin_last;
   assign res_real_o  = valid ? real_i[bin] : '0;
   assign res_imag_o  = valid ? imag_i[bin] : '0;

endmodule

// File: rtl/dft_frame_scheduler.sv
// Frame controller: gates I/Q samples into frames, fetches window coefficients,
// drives the accumulator controls and hands the results to the serializer.
module dft_frame_scheduler
   import dft_pkg::*;
#(
   parameter int  IQ_WIDTH           = DFT_IQ_WIDTH,
   parameter int  WINDOW_WIDTH       = DFT_WINDOW_WIDTH,
   parameter int  ACCUM_WIDTH        = DFT_ACCUM_WIDTH,
   parameter int  NUM_BINS           = DFT_NUM_BINS,
   parameter int  SAMPLE_COUNT_WIDTH = DFT_SAMPLE_COUNT_WIDTH,
   parameter int  TIMEOUT_CYCLES     = DFT_TIMEOUT_CYCLES,
   localparam int BIN_W              = $clog2(NUM_BINS)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  enable_i,
   input  logic [SAMPLE_COUNT_WIDTH-1:0]         cfg_frame_len_i,
   input  logic                                  s_valid_i,
   output logic                                  s_ready_o,
   input  logic [IQ_WIDTH-1:0]                   s_i_i,
   input  logic [IQ_WIDTH-1:0]                   s_q_i,
   output logic                                  win_en_o,
   output logic [SAMPLE_COUNT_WIDTH-1:0]         win_addr_o,
   input  logic [WINDOW_WIDTH-1:0]               win_coeff_i,
   output logic                                  acc_start_o,
   output logic                                  acc_sample_valid_o,
   output logic                                  acc_last_o,
   output logic [IQ_WIDTH-1:0]                   acc_i_o,
   output logic [IQ_WIDTH-1:0]                   acc_q_o,
   output logic [WINDOW_WIDTH-1:0]               acc_win_o,
   input  logic                                  acc_valid_i,
   input  logic                                  acc_busy_i,
   input  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0]  acc_real_i,
   input  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0]  acc_imag_i,
   output logic                                  res_valid_o,
   input  logic                                  res_ready_i,
   output logic [ACCUM_WIDTH-1:0]                res_real_o,
   output logic [ACCUM_WIDTH-1:0]                res_imag_o,
   output logic [BIN_W-1:0]                      res_bin_o,
   output logic                                  res_last_o,
   output logic                                  frame_done_o,
   output logic                                  timeout_o,
   output logic                                  cfg_err_o,
   output dft_state_e                            state_o
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   // Counter runs down to zero in WAIT_ACC; the load value lands timeout_o
   // exactly TIMEOUT_CYCLES cycles after acc_last_o.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 2);

   dft_state_e                    state;
   logic [SAMPLE_COUNT_WIDTH-1:0] len;
   logic [SAMPLE_COUNT_WIDTH-1:0] cnt;
   logic [TMO_W-1:0]              tmo;
   logic                          accept;
   logic                          ser_start;
   logic                          last_hs;

   // Both streams use plain valid/ready: a transfer happens in any cycle where
   // valid and ready are both high; a source holds valid and data until then.
   assign s_ready_o  = (state == ST_RUN) && (cnt < len);
   assign accept     = s_valid_i && s_ready_o;
   assign win_en_o   = accept;
   assign win_addr_o = accept ? cnt : '0;
   assign acc_win_o  = acc_sample_valid_o ? win_coeff_i : '0;
   assign ser_start  = (state == ST_WAIT_ACC) && acc_valid_i;
   assign last_hs    = res_valid_o && res_ready_i && res_last_o;
   assign state_o    = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= ST_IDLE;
         len                <= '0;
         cnt                <= '0;
         tmo                <= '0;
         acc_start_o        <= 1'b0;
         acc_sample_valid_o <= 1'b0;
         acc_last_o         <= 1'b0;
         acc_i_o            <= '0;
         acc_q_o            <= '0;
         timeout_o          <= 1'b0;
         cfg_err_o          <= 1'b0;
      end else begin
         acc_start_o        <= 1'b0;
         timeout_o          <= 1'b0;
         cfg_err_o          <= 1'b0;
         acc_sample_valid_o <= accept;
         acc_last_o         <= accept && (cnt == len - 1'b1);
         acc_i_o            <= accept ? s_i_i : '0;
         acc_q_o            <= accept ? s_q_i : '0;
         if (accept) begin
            cnt <= cnt + 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (enable_i && !acc_busy_i) begin
                  if (cfg_frame_len_i != '0) begin
                     len         <= cfg_frame_len_i;
                     cnt         <= '0;
                     acc_start_o <= 1'b1;
                     state       <= ST_START;
                  end else begin
                     cfg_err_o <= 1'b1;
                  end
               end
            end
            ST_START: state <= ST_RUN;
            ST_RUN: begin
               if (acc_last_o) begin
                  tmo   <= TMO_LOAD;
                  state <= ST_WAIT_ACC;
               end
            end
            ST_WAIT_ACC: begin
               if (acc_valid_i) begin
                  state <= ST_READOUT;
               end else if (tmo == '0) begin
                  timeout_o <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  tmo <= tmo - 1'b1;
               end
            end
            ST_READOUT: begin
               if (last_hs) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   dft_result_serializer #(
      .ACCUM_WIDTH (ACCUM_WIDTH),
      .NUM_BINS    (NUM_BINS)
   ) u_serializer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (ser_start),
      .real_i      (acc_real_i),
      .imag_i      (acc_imag_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_real_o  (res_real_o),
      .res_imag_o  (res_imag_o),
      .res_bin_o   (res_bin_o),
      .res_last_o  (res_last_o),
      .done_o      (frame_done_o)
   );

endmodule

// File: tb/tb_dft_frame_scheduler.sv
// Directed bench for dft_frame_scheduler: per-scenario tasks with inline checks
// against hand-derived values, a negedge event log and a final summary line.
module tb_dft_frame_scheduler;
   import dft_pkg::*;

   localparam int IQW = 16;
   localparam int WW  = 18;
   localparam int AW  = 48;
   localparam int NB  = 16;
   localparam int SCW = 16;
   localparam int TMO = 64;
   localparam int BW  = 4;

   logic                   clk = 1'b0;
   logic                   rst_i;
   logic                   enable_i;
   logic [SCW-1:0]         cfg_frame_len_i;
   logic                   s_valid_i;
   logic                   s_ready_o;
   logic [IQW-1:0]         s_i_i, s_q_i;
   logic                   win_en_o;
   logic [SCW-1:0]         win_addr_o;
   logic [WW-1:0]          win_coeff_i;
   logic                   acc_start_o, acc_sample_valid_o, acc_last_o;
   logic [IQW-1:0]         acc_i_o, acc_q_o;
   logic [WW-1:0]          acc_win_o;
   logic                   acc_valid_i, acc_busy_i;
   logic [NB-1:0][AW-1:0]  acc_real_i, acc_imag_i;
   logic                   res_valid_o, res_ready_i;
   logic [AW-1:0]          res_real_o, res_imag_o;
   logic [BW-1:0]          res_bin_o;
   logic                   res_last_o, frame_done_o, timeout_o, cfg_err_o;
   dft_state_e             state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // event log, filled on the falling edge
   int            start_q[$], addr_q[$], hs_q[$], sv_q[$], win_q[$], bin_q[$], tmo_q[$];
   bit            last_q[$], rlast_q[$];
   logic [31:0]   iq_q[$];
   logic [AW-1:0] real_q[$], imag_q[$];
   bit            last_seen;
   int            last_cyc, accv_cyc, first_resv_cyc, last_hs_cyc, done_cyc;
   int            resv_cnt, done_cnt, err_cnt, sready_cnt;
   logic          rom_en_q;
   logic [SCW-1:0] rom_addr_q;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dft_frame_scheduler #(
      .IQ_WIDTH(IQW), .WINDOW_WIDTH(WW), .ACCUM_WIDTH(AW), .NUM_BINS(NB),
      .SAMPLE_COUNT_WIDTH(SCW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .cfg_frame_len_i(cfg_frame_len_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_i_i(s_i_i), .s_q_i(s_q_i),
      .win_en_o(win_en_o), .win_addr_o(win_addr_o), .win_coeff_i(win_coeff_i),
      .acc_start_o(acc_start_o), .acc_sample_valid_o(acc_sample_valid_o), .acc_last_o(acc_last_o),
      .acc_i_o(acc_i_o), .acc_q_o(acc_q_o), .acc_win_o(acc_win_o),
      .acc_valid_i(acc_valid_i), .acc_busy_i(acc_busy_i),
      .acc_real_i(acc_real_i), .acc_imag_i(acc_imag_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_real_o(res_real_o), .res_imag_o(res_imag_o), .res_bin_o(res_bin_o),
      .res_last_o(res_last_o), .frame_done_o(frame_done_o), .timeout_o(timeout_o),
      .cfg_err_o(cfg_err_o), .state_o(state)
   );

   // window ROM: 1-cycle latency, returns addr+100
   always @(negedge clk) begin
      rom_en_q   = win_en_o;
      rom_addr_q = win_addr_o;
   end
   always @(posedge clk) begin
      #1;
      if (rom_en_q) win_coeff_i = WW'(rom_addr_q + 100);
   end

   always @(negedge clk) begin
      if (acc_start_o) start_q.push_back(cyc);
      if (win_en_o) begin addr_q.push_back(int'(win_addr_o)); hs_q.push_back(cyc); end
      if (acc_sample_valid_o) begin
         sv_q.push_back(cyc); win_q.push_back(int'(acc_win_o));
         last_q.push_back(acc_last_o); iq_q.push_back({acc_i_o, acc_q_o});
      end
      if (acc_last_o) begin last_seen = 1'b1; last_cyc = cyc; end
      if (acc_valid_i) accv_cyc = cyc;
      if (res_valid_o) begin
         resv_cnt++;
         if (first_resv_cyc < 0) first_resv_cyc = cyc;
      end
      if (res_valid_o && res_ready_i) begin
         bin_q.push_back(int'(res_bin_o)); real_q.push_back(res_real_o);
         imag_q.push_back(res_imag_o); rlast_q.push_back(res_last_o);
         if (res_last_o) last_hs_cyc = cyc;
      end
      if (frame_done_o) begin done_cnt++; done_cyc = cyc; end
      if (timeout_o) tmo_q.push_back(cyc);
      if (cfg_err_o) err_cnt++;
      if (s_ready_o) sready_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      start_q.delete(); addr_q.delete(); hs_q.delete(); sv_q.delete(); win_q.delete();
      bin_q.delete(); tmo_q.delete(); last_q.delete(); rlast_q.delete(); iq_q.delete();
      real_q.delete(); imag_q.delete();
      last_seen = 1'b0; last_cyc = -1000; accv_cyc = -1000; first_resv_cyc = -1;
      last_hs_cyc = -1000; done_cyc = -1000;
      resv_cnt = 0; done_cnt = 0; err_cnt = 0; sready_cnt = 0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; enable_i = 1'b0; cfg_frame_len_i = '0; s_valid_i = 1'b0;
      s_i_i = '0; s_q_i = '0; acc_valid_i = 1'b0; acc_busy_i = 1'b0; res_ready_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      tick();
      clear_logs();
   endtask

   task automatic drive_samples(input int n, input bit stall, output int got);
      got = 0;
      for (int c = 0; c < 200 && got < n; c++) begin
         s_valid_i = !(stall && (c % 2 == 1));
         s_i_i     = IQW'(got + 1);
         s_q_i     = IQW'(256 + got);
         #1;
         if (s_valid_i && s_ready_o) got++;
         tick();
      end
      s_valid_i = 1'b0;
   endtask

   task automatic pulse_acc_valid(input int delay);
      for (int c = 0; c < 100 && !last_seen; c++) tick();
      repeat (delay - 1) tick();
      acc_valid_i = 1'b1;
      tick();
      acc_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; enable_i = 1'b1; cfg_frame_len_i = 16'd5; s_valid_i = 1'b1;
      s_i_i = 16'h1234; s_q_i = 16'h5678; acc_valid_i = 1'b0; acc_busy_i = 1'b0;
      res_ready_i = 1'b1; win_coeff_i = '0;
      tick(); tick();
      checks++;
      if ({s_ready_o, win_en_o, win_addr_o, acc_start_o, acc_sample_valid_o, acc_last_o,
           acc_i_o, acc_q_o, acc_win_o, res_valid_o, res_real_o, res_imag_o, res_bin_o,
           res_last_o, frame_done_o, timeout_o, cfg_err_o} !== '0) begin
         failures++; $display("FAIL reset_outputs: some output nonzero under reset, expected all 0");
      end
      checks++;
      if (state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
      enable_i = 1'b0; s_valid_i = 1'b0; rst_i = 1'b0;
      clear_logs();
      tick(); tick();
      checks++;
      if (start_q.size() !== 0) begin failures++; $display("FAIL reset_no_start: got %0d starts expected 0", start_q.size()); end
   endtask

   task automatic test_single_frame();
      int got, s;
      do_reset();
      cfg_frame_len_i = 16'd4; enable_i = 1'b1;
      drive_samples(4, 1'b0, got);
      enable_i = 1'b0;
      pulse_acc_valid(3);
      res_ready_i = 1'b1;
      for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
      repeat (3) tick();
      res_ready_i = 1'b0;
      s = (start_q.size() > 0) ? start_q[0] : -1000;
      checks++;
      if (got !== 4) begin failures++; $display("FAIL single_accepted: got %0d expected 4", got); end
      checks++;
      if (start_q.size() !== 1) begin failures++; $display("FAIL single_starts: got %0d expected 1", start_q.size()); end
      checks++;
      if (sv_q.size() !== 4) begin failures++; $display("FAIL single_sample_valids: got %0d expected 4", sv_q.size()); end
      for (int k = 0; k < sv_q.size() && k < 4; k++) begin
         checks++;
         if (win_q[k] !== 100 + k) begin failures++; $display("FAIL single_win[%0d]: got %0d expected %0d", k, win_q[k], 100 + k); end
         checks++;
         if (last_q[k] !== (k == 3)) begin failures++; $display("FAIL single_last[%0d]: got %0d expected %0d", k, last_q[k], k == 3); end
         checks++;
         if (iq_q[k] !== {IQW'(k + 1), IQW'(256 + k)}) begin failures++; $display("FAIL single_iq[%0d]: got %h expected %h", k, iq_q[k], {IQW'(k + 1), IQW'(256 + k)}); end
      end
      checks++;
      if (sv_q.size() > 0 && sv_q[0] !== s + 2) begin failures++; $display("FAIL single_first_sv_cycle: got %0d expected %0d", sv_q[0], s + 2); end
      checks++;
      if (last_cyc !== s + 5) begin failures++; $display("FAIL single_last_cycle: got %0d expected %0d", last_cyc, s + 5); end
      checks++;
      if (first_resv_cyc !== accv_cyc + 1) begin failures++; $display("FAIL single_first_res: got %0d expected %0d", first_resv_cyc, accv_cyc + 1); end
      checks++;
      if (last_hs_cyc - first_resv_cyc !== 15) begin failures++; $display("FAIL single_readout_len: got %0d expected 15", last_hs_cyc - first_resv_cyc); end
      checks++;
      if (bin_q.size() !== 16) begin failures++; $display("FAIL single_results: got %0d expected 16", bin_q.size()); end
      for (int k = 0; k < bin_q.size() && k < 16; k++) begin
         checks++;
         if (bin_q[k] !== k || real_q[k] !== AW'(48'h1000 + 3 * k) || imag_q[k] !== AW'(48'hA0000 + k) || rlast_q[k] !== (k == 15)) begin
            failures++;
            $display("FAIL single_result[%0d]: got bin %0d re %h im %h last %0d expected bin %0d re %h im %h last %0d",
                     k, bin_q[k], real_q[k], imag_q[k], rlast_q[k], k, AW'(48'h1000 + 3 * k), AW'(48'hA0000 + k), k == 15);
         end
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1) begin failures++; $display("FAIL single_done: got count %0d at %0d expected 1 at %0d", done_cnt, done_cyc, last_hs_cyc + 1); end
      checks++;
      if (state !== ST_IDLE) begin failures++; $display("FAIL single_end_state: got %0d expected %0d", state, ST_IDLE); end
   endtask

   task automatic test_stalled_source();
      int got;
      do_reset();
      cfg_frame_len_i = 16'd3; enable_i = 1'b1;
      drive_samples(3, 1'b1, got);
      enable_i = 1'b0;
      pulse_acc_valid(1);
      res_ready_i = 1'b1;
      for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
      tick();
      res_ready_i = 1'b0;
      checks++;
      if (sv_q.size() !== 3 || hs_q.size() !== 3) begin failures++; $display("FAIL stall_counts: got %0d valids %0d handshakes expected 3 3", sv_q.size(), hs_q.size()); end
      for (int k = 0; k < 3 && k < sv_q.size() && k < hs_q.size(); k++) begin
         checks++;
         if (addr_q[k] !== k) begin failures++; $display("FAIL stall_addr[%0d]: got %0d expected %0d", k, addr_q[k], k); end
         checks++;
         if (sv_q[k] !== hs_q[k] + 1) begin failures++; $display("FAIL stall_lag[%0d]: got %0d expected %0d", k, sv_q[k], hs_q[k] + 1); end
         checks++;
         if (last_q[k] !== (k == 2)) begin failures++; $display("FAIL stall_last[%0d]: got %0d expected %0d", k, last_q[k], k == 2); end
      end
      checks++;
      if (hs_q.size() >= 2 && hs_q[1] - hs_q[0] !== 2) begin failures++; $display("FAIL stall_gap: got %0d expected 2", hs_q[1] - hs_q[0]); end
      checks++;
      if (bin_q.size() !== 16 || done_cnt !== 1) begin failures++; $display("FAIL stall_readout: got %0d results %0d done expected 16 1", bin_q.size(), done_cnt); end
   endtask

   task automatic test_backpressure();
      int got, stall_left, stalled;
      do_reset();
      cfg_frame_len_i = 16'd2; enable_i = 1'b1;
      drive_samples(2, 1'b0, got);
      pulse_acc_valid(1);
      stall_left = 5; stalled = 0;
      res_ready_i = 1'b1;
      for (int c = 0; c < 80 && done_cnt == 0; c++) begin
         if (res_valid_o && res_bin_o == 4'd7 && stall_left > 0) begin
            res_ready_i = 1'b0;
            stall_left--; stalled++;
            checks++;
            if (res_bin_o !== 4'd7 || res_real_o !== 48'h1015 || res_imag_o !== 48'hA0007 || res_last_o !== 1'b0) begin
               failures++;
               $display("FAIL bp_hold: got bin %0d re %h im %h expected bin 7 re 1015 im a0007", res_bin_o, res_real_o, res_imag_o);
            end
         end else begin
            res_ready_i = 1'b1;
         end
         tick();
      end
      repeat (3) tick();
      enable_i = 1'b0;
      res_ready_i = 1'b0;
      checks++;
      if (stalled !== 5) begin failures++; $display("FAIL bp_stall_cycles: got %0d expected 5", stalled); end
      checks++;
      if (bin_q.size() !== 16) begin failures++; $display("FAIL bp_results: got %0d expected 16", bin_q.size()); end
      for (int k = 0; k < bin_q.size() && k < 16; k++) begin
         checks++;
         if (bin_q[k] !== k || real_q[k] !== AW'(48'h1000 + 3 * k)) begin failures++; $display("FAIL bp_result[%0d]: got bin %0d re %h expected bin %0d re %h", k, bin_q[k], real_q[k], k, AW'(48'h1000 + 3 * k)); end
      end
      checks++;
      if (last_hs_cyc - first_resv_cyc !== 20) begin failures++; $display("FAIL bp_readout_len: got %0d expected 20", last_hs_cyc - first_resv_cyc); end
      checks++;
      if (start_q.size() !== 2) begin failures++; $display("FAIL bp_starts: got %0d expected 2", start_q.size()); end
      checks++;
      if (start_q.size() >= 2 && start_q[1] !== last_hs_cyc + 2) begin failures++; $display("FAIL bp_restart_cycle: got %0d expected %0d", start_q[1], last_hs_cyc + 2); end
   endtask

   task automatic test_timeout();
      int got;
      do_reset();
      cfg_frame_len_i = 16'd2; enable_i = 1'b1;
      drive_samples(2, 1'b0, got);
      enable_i = 1'b0;
      res_ready_i = 1'b1;
      for (int c = 0; c < 120 && tmo_q.size() == 0; c++) tick();
      repeat (3) tick();
      res_ready_i = 1'b0;
      checks++;
      if (tmo_q.size() !== 1) begin failures++; $display("FAIL timeout_pulses: got %0d expected 1", tmo_q.size()); end
      checks++;
      if (tmo_q.size() > 0 && tmo_q[0] !== last_cyc + 64) begin failures++; $display("FAIL timeout_cycle: got %0d expected %0d", tmo_q[0], last_cyc + 64); end
      checks++;
      if (resv_cnt !== 0 || done_cnt !== 0) begin failures++; $display("FAIL timeout_no_results: got %0d valid %0d done expected 0 0", resv_cnt, done_cnt); end
      checks++;
      if (state !== ST_IDLE) begin failures++; $display("FAIL timeout_state: got %0d expected %0d", state, ST_IDLE); end
   endtask

   task automatic test_illegal_cfg();
      int rel;
      do_reset();
      cfg_frame_len_i = '0; enable_i = 1'b1; s_valid_i = 1'b1;
      repeat (6) tick();
      enable_i = 1'b0; s_valid_i = 1'b0;
      tick(); tick();
      checks++;
      if ((err_cnt > 0) !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse: got %0d pulses expected at least 1", err_cnt); end
      checks++;
      if (start_q.size() !== 0) begin failures++; $display("FAIL cfg_err_no_start: got %0d expected 0", start_q.size()); end
      checks++;
      if (sready_cnt !== 0) begin failures++; $display("FAIL cfg_err_sready: got %0d cycles high expected 0", sready_cnt); end
      acc_busy_i = 1'b1; cfg_frame_len_i = 16'd3; enable_i = 1'b1;
      repeat (5) tick();
      checks++;
      if (start_q.size() !== 0) begin failures++; $display("FAIL busy_blocks_start: got %0d expected 0", start_q.size()); end
      rel = cyc;
      acc_busy_i = 1'b0;
      tick(); tick(); tick();
      enable_i = 1'b0;
      checks++;
      if (start_q.size() !== 1 || start_q[0] !== rel + 1) begin failures++; $display("FAIL busy_release_start: got %0d starts first at %0d expected 1 at %0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, rel + 1); end
   endtask

   task automatic test_reset_mid_frame();
      int got;
      do_reset();
      cfg_frame_len_i = 16'd8; enable_i = 1'b1;
      drive_samples(2, 1'b0, got);
      checks++;
      if (got !== 2 || addr_q.size() !== 2) begin failures++; $display("FAIL midrst_pre: got %0d accepted %0d addrs expected 2 2", got, addr_q.size()); end
      rst_i = 1'b1; s_valid_i = 1'b1;
      tick();
      checks++;
      if ({s_ready_o, win_en_o, win_addr_o, acc_start_o, acc_sample_valid_o, acc_last_o,
           acc_i_o, acc_q_o, acc_win_o, res_valid_o, res_real_o, res_imag_o, res_bin_o,
           res_last_o, frame_done_o, timeout_o, cfg_err_o} !== '0) begin
         failures++; $display("FAIL midrst_outputs: some output nonzero after reset, expected all 0");
      end
      checks++;
      if (state !== ST_IDLE) begin failures++; $display("FAIL midrst_state: got %0d expected %0d", state, ST_IDLE); end
      rst_i = 1'b0; s_valid_i = 1'b0;
      clear_logs();
      cfg_frame_len_i = 16'd3;
      drive_samples(3, 1'b0, got);
      enable_i = 1'b0;
      checks++;
      if (got !== 3 || addr_q.size() !== 3) begin failures++; $display("FAIL midrst_restart_count: got %0d accepted %0d addrs expected 3 3", got, addr_q.size()); end
      for (int k = 0; k < 3 && k < addr_q.size(); k++) begin
         checks++;
         if (addr_q[k] !== k) begin failures++; $display("FAIL midrst_addr[%0d]: got %0d expected %0d", k, addr_q[k], k); end
      end
   endtask

   initial begin
      for (int b = 0; b < NB; b++) begin
         acc_real_i[b] = AW'(48'h1000 + 3 * b);
         acc_imag_i[b] = AW'(48'hA0000 + b);
      end
      clear_logs();
      test_reset();
      test_single_frame();
      test_stalled_source();
      test_backpressure();
      test_timeout();
      test_illegal_cfg();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
